// File: rtl/decoder_rr_arbiter8.sv
// Round-robin arbiter for 8 requesters driving a registered index and its one-hot decode.
// Grant latency one cycle; grant held until release or HOLD_MAX expiry, one dead GAP cycle between owners.
module decoder_rr_arbiter8 #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int HW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t        state, state_n;
  logic [2:0]    ptr, ptr_n, idx_n, win, cand;
  logic [HW-1:0] hold_cnt, hold_n;
  logic          valid_n, to_n, found, hold_hit;

  // Rotating priority search: walking offsets high-to-low leaves the lowest offset from ptr as winner.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    cand  = '0;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr + 3'(i);
      if (req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign hold_hit = (HOLD_MAX != 0) && (int'(hold_cnt) == HOLD_MAX - 1);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = gnt_idx;
    hold_n  = hold_cnt;
    valid_n = 1'b0;
    to_n    = 1'b0;
    case (state)
      GRANT: begin
        if (!req[gnt_idx]) begin
          state_n = GAP;
          ptr_n   = gnt_idx + 3'd1;
        end else if (hold_hit) begin
          state_n = GAP;
          ptr_n   = gnt_idx + 3'd1;
          to_n    = 1'b1;
        end else begin
          valid_n = 1'b1;
          if (hold_cnt != '1) hold_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        if (en && found) begin
          state_n = GRANT;
          idx_n   = win;
          valid_n = 1'b1;
          hold_n  = '0;
        end else begin
          state_n = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      gnt       <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_n;
      gnt_idx   <= idx_n;
      gnt_valid <= valid_n;
      gnt       <= valid_n ? (8'b1 << idx_n) : 8'h00;
      timeout   <= to_n;
    end
  end

endmodule

// File: tb/tb_decoder_rr_arbiter8.sv
// Bench for decoder_rr_arbiter8: directed scenarios plus random traffic against an ownership model.
module tb_decoder_rr_arbiter8;
  localparam int HM = 4;

  logic       clk, rst, en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid, timeout;
  logic [12:0] act;

  int checks = 0;
  int passes = 0;

  // Reference model: who owns the grant, how many grant cycles it has had, and where the search starts.
  bit m_valid, m_to;
  int m_idx, m_held, m_ptr;

  decoder_rr_arbiter8 #(.HOLD_MAX(HM)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  assign act = {gnt, gnt_idx, gnt_valid, timeout};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int pick(int p, logic [7:0] r);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  function automatic logic [12:0] exp_vec();
    logic [7:0] g;
    g = m_valid ? (8'h01 << m_idx) : 8'h00;
    return {g, 3'(m_idx), m_valid, m_to};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_to = 0; m_idx = 0; m_held = 0; m_ptr = 0;
  endtask

  task automatic model_step();
    int w;
    m_to = 0;
    if (!m_valid) begin
      w = pick(m_ptr, req);
      if (en && w >= 0) begin
        m_valid = 1; m_idx = w; m_held = 1;
      end
    end else if (!req[m_idx]) begin
      m_valid = 0; m_ptr = (m_idx + 1) % 8;
    end else if (HM != 0 && m_held == HM) begin
      m_valid = 0; m_ptr = (m_idx + 1) % 8; m_to = 1;
    end else begin
      m_held++;
    end
  endtask

  // Advance one clock; model consumes the inputs present at the edge, outputs sampled 1 time unit later.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; req = 8'($urandom);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (act !== 13'h0) $display("FAIL reset_hold act=%h exp=%h", act, 13'h0);
    else passes++;
    rst = 1'b0; req = 8'h00;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (act !== exp_vec() || gnt !== 8'h00) $display("FAIL reset_idle act=%h exp=%h", act, exp_vec());
      else passes++;
    end
  endtask

  task automatic test_basic();
    en = 1'b1; req = 8'h24;
    tick();
    checks++;
    if (gnt !== 8'h04 || gnt_idx !== 3'd2 || gnt_valid !== 1'b1)
      $display("FAIL basic_first gnt=%h idx=%0d exp gnt=04 idx=2", gnt, gnt_idx);
    else passes++;
    req = 8'h20;
    tick();
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd2)
      $display("FAIL basic_gap gnt=%h idx=%0d exp gnt=00 idx=2", gnt, gnt_idx);
    else passes++;
    tick();
    checks++;
    if (gnt !== 8'h20 || gnt_idx !== 3'd5) $display("FAIL basic_second gnt=%h idx=%0d exp gnt=20 idx=5", gnt, gnt_idx);
    else passes++;
    req = 8'h00;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (act !== exp_vec()) $display("FAIL basic_release act=%h exp=%h", act, exp_vec());
      else passes++;
    end
  endtask

  task automatic test_fairness();
    logic [7:0] eg;
    rst_pulse();
    en = 1'b1; req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      eg = 8'h01 << (k % 8);
      for (int c = 0; c < 2; c++) begin
        tick();
        checks++;
        if (gnt !== eg || gnt_idx !== 3'(k % 8) || act !== exp_vec())
          $display("FAIL fair_owner k=%0d gnt=%h idx=%0d exp gnt=%h idx=%0d", k, gnt, gnt_idx, eg, k % 8);
        else passes++;
      end
      req = 8'hFF & ~eg;
      tick();
      req = 8'hFF;
      checks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0) $display("FAIL fair_gap k=%0d gnt=%h exp=00", k, gnt);
      else passes++;
    end
  endtask

  task automatic test_timeout();
    rst_pulse();
    en = 1'b1; req = 8'h01;
    for (int c = 0; c < HM; c++) begin
      tick();
      checks++;
      if (gnt !== 8'h01 || timeout !== 1'b0) $display("FAIL to_hold c=%0d gnt=%h to=%b exp gnt=01 to=0", c, gnt, timeout);
      else passes++;
    end
    tick();
    checks++;
    if (gnt !== 8'h00 || timeout !== 1'b1 || gnt_valid !== 1'b0)
      $display("FAIL to_pulse gnt=%h to=%b exp gnt=00 to=1", gnt, timeout);
    else passes++;
    tick();
    checks++;
    if (gnt !== 8'h01 || timeout !== 1'b0 || act !== exp_vec())
      $display("FAIL to_regrant gnt=%h to=%b exp gnt=01 to=0", gnt, timeout);
    else passes++;
  endtask

  task automatic test_en_during_grant();
    rst_pulse();
    en = 1'b1; req = 8'h08;
    tick();
    en = 1'b0; req = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (gnt !== 8'h08 || gnt_idx !== 3'd3) $display("FAIL en_hold gnt=%h exp=08", gnt);
      else passes++;
    end
    req = 8'hF7;
    tick();
    req = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (gnt !== 8'h00 || act !== exp_vec()) $display("FAIL en_blocked c=%0d gnt=%h exp=00", c, gnt);
      else passes++;
    end
    en = 1'b1;
    tick();
    checks++;
    if (gnt !== 8'h10 || gnt_idx !== 3'd4) $display("FAIL en_resume gnt=%h exp=10", gnt);
    else passes++;
  endtask

  task automatic test_reset_mid_grant();
    rst_pulse();
    en = 1'b1; req = 8'h40;
    tick();
    checks++;
    if (gnt !== 8'h40) $display("FAIL mid_pre gnt=%h exp=40", gnt);
    else passes++;
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (act !== 13'h0) $display("FAIL mid_async act=%h exp=%h", act, 13'h0);
    else passes++;
    req = 8'hC1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0 || act !== exp_vec()) $display("FAIL mid_after gnt=%h exp=01", gnt);
    else passes++;
  endtask

  task automatic test_random();
    rst_pulse();
    req = 8'h00; en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      else if ($urandom_range(0, 5) == 0 && m_valid) req[m_idx] = 1'b0;
      tick();
      checks++;
      if (act !== exp_vec()) $display("FAIL rand_model c=%0d act=%h exp=%h", c, act, exp_vec());
      else passes++;
      checks++;
      if ($countones(gnt) > 1 || gnt_valid !== (|gnt) || (timeout && gnt_valid))
        $display("FAIL rand_invariant c=%0d gnt=%h vld=%b to=%b exp onehot/consistent", c, gnt, gnt_valid, timeout);
      else passes++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 8'h00;
    model_reset();
    test_reset();
    test_basic();
    test_fairness();
    test_timeout();
    test_en_during_grant();
    test_reset_mid_grant();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
